// File: rtl/quadra_rr_sched.sv
// Round-robin front end for a shared quadra pipeline.
//   Grants at most one requester per cycle, steers its x onto quadra, and tags
//   each accepted sample with the requester ID. The {valid,id} tag pipe is
//   matched to quadra latency, so rsp_y (= q_y) is returned with the owning ID.
//   An enable/drain FSM stops granting and lets in-flight samples drain.
// Ports:
//   clk, rst_b            clock, async active-low reset
//   en                    1: grant requests, 0: stop granting and drain
//   req_valid/req_x       per-requester request and x (requester i at [i*X_W +: X_W])
//   req_ready             one-hot (or zero) grant
//   q_x / q_y             to / from quadra
//   rsp_valid/rsp_id/rsp_y  tagged result
//   idle                  FSM idle and nothing in flight
module quadra_rr_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned X_W   = 24,
    parameter int unsigned Y_W   = 24,
    parameter int unsigned LAT   = 3,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*X_W-1:0]   req_x,
    output logic [N_REQ-1:0]       req_ready,
    output logic [X_W-1:0]         q_x,
    input  logic [Y_W-1:0]         q_y,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [Y_W-1:0]         rsp_y,
    output logic                   idle
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                     state_q, state_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [LAT-1:0][ID_W-1:0]   tag_id_q, tag_id_d;

    logic                       gnt_vld;
    logic [ID_W-1:0]            gnt_idx;
    logic                       accept;

    // First valid requester at or after the pointer, wrapping at N_REQ-1.
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(ptr_q) + i) % N_REQ);
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // en gates the grant combinationally so a drop takes effect in the same cycle.
    assign accept    = (state_q == StRun) && en && gnt_vld;
    assign req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign q_x       = accept ? req_x[gnt_idx*X_W +: X_W] : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = accept;
        tag_id_d[0]  = accept ? gnt_idx : '0;
        for (int unsigned k = 1; k < LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    // Drain exit looks at next-cycle tag valids so idle rises the cycle after
    // the last result rather than one cycle later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = (|tag_vld_d) ? StDrain : StIdle;
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if (!(|tag_vld_d)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign rsp_valid = tag_vld_q[LAT-1];
    assign rsp_id    = tag_id_q[LAT-1];
    assign rsp_y     = q_y;
    assign idle      = (state_q == StIdle) && !(|tag_vld_q);

endmodule

// File: tb/tb_quadra_rr_sched.sv
module tb_quadra_rr_sched;

    logic        clk;
    logic        rst_b;
    logic        en;
    logic [3:0]  req_valid;
    logic [95:0] req_x;
    logic [3:0]  req_ready;
    logic [23:0] q_x;
    logic [23:0] q_y;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_y;
    logic        idle;

    int n_cmp;
    int n_err;

    quadra_rr_sched #(
        .N_REQ(4), .X_W(24), .Y_W(24), .LAT(3)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (en),
        .req_valid(req_valid),
        .req_x    (req_x),
        .req_ready(req_ready),
        .q_x      (q_x),
        .q_y      (q_y),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_y    (rsp_y),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in quadra: y = (x1*x1) << 10 + x2, three register stages.
    function automatic logic [23:0] f_quadra(input logic [23:0] x);
        logic [13:0] sq;
        sq = 14'(x[23:17] * x[23:17]);
        return {sq, 10'b0} + {7'b0, x[16:0]};
    endfunction

    logic [23:0] qp0, qp1, qp2;
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            qp0 <= '0; qp1 <= '0; qp2 <= '0;
        end else begin
            qp0 <= q_x; qp1 <= qp0; qp2 <= qp1;
        end
    end
    assign q_y = f_quadra(qp2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; req_valid = '0; req_x = '0;
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        en = 1'b0; req_valid = 4'b1111; req_x = '1;
        rst_b = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", idle); end
        n_cmp++; if (q_x !== 24'h0) begin n_err++; $display("FAIL reset_q_x got %h want 000000", q_x); end
        tick();
        rst_b = 1'b1;
        req_valid = '0; req_x = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1;
        tick();
        req_valid = 4'b0001;
        req_x[23:0] = 24'h020000;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b want 0001", req_ready); end
        n_cmp++; if (q_x !== 24'h020000) begin n_err++; $display("FAIL single_q_x got %h want 020000", q_x); end
        tick();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== (k == 3)) begin
                n_err++; $display("FAIL single_rsp_valid T+%0d got %b want %b", k, rsp_valid, k == 3);
            end
            if (k == 3) begin
                n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id got %0d want 0", rsp_id); end
                n_cmp++; if (rsp_y !== 24'h000400) begin n_err++; $display("FAIL single_rsp_y got %h want 000400", rsp_y); end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [23:0] rr_x [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rr_x[i] = {7'(i + 2), 17'(i * 5 + 3)};
            req_x[i*24 +: 24] = rr_x[i];
        end
        en = 1'b1;
        tick();
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            n_cmp++;
            if (req_ready !== ((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000)) begin
                n_err++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready,
                                  (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
            end
            n_cmp++;
            if (rsp_valid !== (c >= 3)) begin
                n_err++; $display("FAIL rr_rsp_valid c=%0d got %b want %b", c, rsp_valid, c >= 3);
            end
            if (c >= 3) begin
                n_cmp++;
                if (rsp_id !== 2'((c - 3) % 4) || rsp_y !== f_quadra(rr_x[(c - 3) % 4])) begin
                    n_err++; $display("FAIL rr_rsp c=%0d got id=%0d y=%h want id=%0d y=%h", c, rsp_id,
                                      rsp_y, (c - 3) % 4, f_quadra(rr_x[(c - 3) % 4]));
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0011;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_grant got %b want 0001", req_ready); end
        tick();
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_ptr_after got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_drain();
        do_reset();
        en = 1'b1;
        tick();
        req_valid = 4'b1111;
        tick(); tick(); tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL drain_ready k=%0d got %b want 0000", k, req_ready); end
            n_cmp++; if (q_x !== 24'h0) begin n_err++; $display("FAIL drain_q_x k=%0d got %h want 000000", k, q_x); end
            n_cmp++; if (rsp_valid !== (k < 3)) begin n_err++; $display("FAIL drain_rsp_valid k=%0d got %b want %b", k, rsp_valid, k < 3); end
            if (k < 3) begin
                n_cmp++; if (rsp_id !== 2'(k)) begin n_err++; $display("FAIL drain_rsp_id k=%0d got %0d want %0d", k, rsp_id, k); end
            end
            n_cmp++; if (idle !== (k == 3)) begin n_err++; $display("FAIL drain_idle k=%0d got %b want %b", k, idle, k == 3); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        tick();
        req_valid = 4'b0101;
        tick(); tick();
        req_valid = '0;
        tick();
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_rsp_valid got %b want 1", rsp_valid); end
        #1;
        rst_b = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL arst_idle got %b want 1", idle); end
        @(posedge clk);
        #3;
        rst_b = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale k=%0d got %b want 0", k, rsp_valid); end
            tick();
        end
    endtask

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [23:0] y;
    } exp_t;

    task automatic test_random();
        exp_t        sb [$];
        exp_t        e;
        logic        prev_en;
        logic [1:0]  mptr;
        logic [3:0]  exp_ready;
        logic [1:0]  g;
        logic        found;
        int          ncyc;
        ncyc = 10000;
        do_reset();
        prev_en = 1'b0;
        mptr    = 2'd0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            en        = (cyc < ncyc - 6) ? ($urandom_range(0, 7) != 0) : 1'b0;
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) req_x[i*24 +: 24] = 24'($urandom);
            #1;
            found = 1'b0; g = 2'd0; exp_ready = 4'b0;
            if (prev_en && en) begin
                for (int i = 0; i < 4; i++) begin
                    if (!found && req_valid[2'(mptr + 2'(i))]) begin
                        found = 1'b1;
                        g = 2'(mptr + 2'(i));
                    end
                end
                if (found) exp_ready = 4'b0001 << g;
            end
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_err++; $display("FAIL rand_grant cyc=%0d got %b want %b", cyc, req_ready, exp_ready);
            end
            n_cmp++;
            if (!$onehot0(req_ready)) begin
                n_err++; $display("FAIL rand_onehot cyc=%0d got %b want one-hot or zero", cyc, req_ready);
            end
            if (found) begin
                n_cmp++;
                if (q_x !== req_x[g*24 +: 24]) begin
                    n_err++; $display("FAIL rand_q_x cyc=%0d got %h want %h", cyc, q_x, req_x[g*24 +: 24]);
                end
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_y !== e.y) begin
                    n_err++; $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d y=%h want v=1 id=%0d y=%h",
                                      cyc, rsp_valid, rsp_id, rsp_y, e.id, e.y);
                end
            end else begin
                n_cmp++;
                if (rsp_valid !== 1'b0) begin
                    n_err++; $display("FAIL rand_rsp_spurious cyc=%0d got v=%b want v=0", cyc, rsp_valid);
                end
            end
            if (found) begin
                e.due = cyc + 3;
                e.id  = g;
                e.y   = f_quadra(req_x[g*24 +: 24]);
                sb.push_back(e);
                mptr = g + 2'd1;
            end
            prev_en = en;
            tick();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL rand_outstanding got %0d want 0", sb.size());
        end
        n_cmp++;
        if (idle !== 1'b1) begin
            n_err++; $display("FAIL rand_final_idle got %b want 1", idle);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_b = 1'b1; en = 1'b0; req_valid = '0; req_x = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drain();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
